// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants and the slave state type
package spi_pkg;
    localparam int SPI_BYTE_W = 8;
    localparam logic [SPI_BYTE_W-1:0] DEF_IDLE_BYTE = 8'hFF;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the EN_/RDY_ method signals of the SPI slave
interface spi_slave_if;
    import spi_pkg::*;
    logic                  sck;
    logic                  mosi;
    logic                  ss;
    logic                  miso;
    logic                  miso_en;
    logic [SPI_BYTE_W-1:0] loadTx_data;
    logic                  EN_loadTx;
    logic                  RDY_loadTx;
    logic                  EN_getRx;
    logic [SPI_BYTE_W-1:0] getRx;
    logic                  RDY_getRx;
    logic                  selected;
    logic                  overrun;
    modport slave (
        input  sck, mosi, ss, loadTx_data, EN_loadTx, EN_getRx,
        output miso, miso_en, RDY_loadTx, getRx, RDY_getRx, selected, overrun
    );
    modport master (
        output sck, mosi, ss, loadTx_data, EN_loadTx, EN_getRx,
        input  miso, miso_en, RDY_loadTx, getRx, RDY_getRx, selected, overrun
    );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-flop synchroniser with a change-detect register
module spi_sync_edge #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_edge
);
    logic [N-1:0] r_sync;
    logic         r_prev;
    // shift the pin through the chain and remember the last settled level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {N{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
            r_prev <= r_sync[N-1];
        end
    end
    assign o_q    = r_sync[N-1];
    assign o_edge = r_sync[N-1] ^ r_prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder with single-entry TX/RX holding registers
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = DEF_IDLE_BYTE,
    parameter int                    SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst_n,
    spi_slave_if.slave bus
);
    state_t                r_state, w_state_nxt;
    logic                  w_sck_q, w_sck_edge, w_ss_q, w_ss_edge;
    logic                  w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [2:0]            r_bitcnt;
    logic [SPI_BYTE_W-1:0] r_tx_shift, r_tx_hold, r_rx_hold;
    logic [SPI_BYTE_W-2:0] r_rx_shift;
    logic                  r_tx_full, r_rx_full, r_overrun;
    logic                  w_load, w_tx_shift, w_rx_bit, w_rx_done, w_rx_store;
    logic [SPI_BYTE_W-1:0] w_tx_next, w_rx_byte;

    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .i_d(bus.sck), .o_q(w_sck_q), .o_edge(w_sck_edge)
    );
    spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .i_d(bus.ss), .o_q(w_ss_q), .o_edge(w_ss_edge)
    );

    assign w_sck_rise = w_sck_edge & w_sck_q;
    assign w_sck_fall = w_sck_edge & ~w_sck_q;
    assign w_ss_rise  = w_ss_edge & w_ss_q;
    assign w_ss_fall  = w_ss_edge & ~w_ss_q;
    assign w_tx_next  = r_tx_full ? r_tx_hold : IDLE_BYTE;
    assign w_rx_byte  = {r_rx_shift, r_mosi_sync[SYNC_STAGES-1]};
    assign w_rx_done  = w_rx_bit && r_bitcnt == 3'd7;
    assign w_rx_store = w_rx_done && (!r_rx_full || bus.EN_getRx);

    // mosi shares the sck synchroniser depth so each sample lines up with its edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mosi_sync <= '0;
        else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // select tracking and per-edge strobes; sck is ignored while deselected or deselecting
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_tx_shift  = 1'b0;
        w_rx_bit    = 1'b0;
        if (r_state == IDLE) begin
            w_state_nxt = w_ss_fall ? ACTIVE : IDLE;
            w_load      = w_ss_fall;
        end else if (w_ss_rise) begin
            w_state_nxt = IDLE;
        end else begin
            w_rx_bit   = w_sck_rise;
            w_load     = w_sck_fall && r_bitcnt == 3'd0;
            w_tx_shift = w_sck_fall && r_bitcnt != 3'd0;
        end
    end

    // bit counter and shift registers; miso is the top bit of tx_shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt   <= 3'd0;
            r_tx_shift <= '1;
            r_rx_shift <= '0;
        end else begin
            if (w_load)          r_tx_shift <= w_tx_next;
            else if (w_tx_shift) r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
            if (w_rx_bit)        r_rx_shift <= w_rx_byte[SPI_BYTE_W-2:0];
            if (r_state == IDLE || w_ss_rise) r_bitcnt <= 3'd0;
            else if (w_rx_bit)                r_bitcnt <= r_bitcnt + 3'd1;
        end
    end

    // TX holding register: a byte-start load wins over a same-cycle write only when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_full <= 1'b0;
            r_tx_hold <= '0;
        end else if (w_load && r_tx_full) begin
            r_tx_full <= 1'b0;
        end else if (bus.EN_loadTx) begin
            r_tx_full <= 1'b1;
            r_tx_hold <= bus.loadTx_data;
        end
    end

    // RX holding register and sticky overrun; a same-cycle pop makes room for the new byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_full <= 1'b0;
            r_rx_hold <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_rx_store) begin
                r_rx_full <= 1'b1;
                r_rx_hold <= w_rx_byte;
            end else if (bus.EN_getRx) begin
                r_rx_full <= 1'b0;
            end
            if (w_rx_done && r_rx_full && !bus.EN_getRx) r_overrun <= 1'b1;
            else if (bus.EN_getRx)                       r_overrun <= 1'b0;
        end
    end

    assign bus.miso       = r_tx_shift[SPI_BYTE_W-1];
    assign bus.miso_en    = r_state == ACTIVE;
    assign bus.RDY_loadTx = !r_tx_full;
    assign bus.getRx      = r_rx_hold;
    assign bus.RDY_getRx  = r_rx_full;
    assign bus.selected   = !w_ss_q;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: mode-0 master model driving spi_slave, with RX/TX scoreboards
module tb_spi_slave;
    import spi_pkg::*;
    localparam int H = 4;

    typedef struct {
        logic       load;
        logic [7:0] ld;
        logic [7:0] mosi;
        logic [7:0] miso;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    vec_t       vecs[5];
    logic [3:0] rdy;
    logic [7:0] junk;

    always #5 clk = ~clk;

    spi_slave_if bus();
    spi_slave dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        bus.loadTx_data = d;
        bus.EN_loadTx   = 1'b1;
        @(negedge clk);
        bus.EN_loadTx   = 1'b0;
    endtask

    task automatic deselect();
        bus.ss = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic read_rx(input string name);
        int         n = 0;
        logic [7:0] exp;
        while (!bus.RDY_getRx && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.RDY_getRx) begin
            chk({name, "_timeout"}, 32'(bus.RDY_getRx), 32'd1);
        end else begin
            exp = rxq.size() != 0 ? rxq.pop_front() : 8'hxx;
            chk(name, 32'(bus.getRx), 32'(exp));
            bus.EN_getRx = 1'b1;
            @(negedge clk);
            bus.EN_getRx = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int n, input logic pop_hit,
                        input logic load_hit, input logic [7:0] load_val,
                        output logic [7:0] rx, output logic [3:0] tr);
        logic [7:0] exp;
        rx = '0;
        tr = '0;
        for (int i = 0; i < n; i++) begin
            bus.mosi = tx[7-i];
            repeat (H) @(negedge clk);
            rx = {rx[6:0], bus.miso};
            bus.sck = 1'b1;
            for (int c = 0; c < H; c++) begin
                @(negedge clk);
                if (i == 7) tr[c] = bus.RDY_getRx;
                if (i == 7 && pop_hit) begin
                    if (c == 1) begin
                        exp = rxq.size() != 0 ? rxq.pop_front() : 8'hxx;
                        chk("rx_same_cycle_pop", 32'(bus.getRx), 32'(exp));
                    end
                    bus.EN_getRx = (c == 1);
                end
            end
            bus.sck = 1'b0;
            for (int c = 0; c < H; c++) begin
                @(negedge clk);
                if (i == 7 && load_hit) begin
                    bus.loadTx_data = load_val;
                    bus.EN_loadTx   = (c == 1);
                end
            end
        end
    endtask

    task automatic byte_xfer(input logic [7:0] tx, input logic [7:0] exp_miso, input logic store,
                             input logic pop_hit, input logic load_hit, input logic [7:0] load_val,
                             output logic [3:0] tr);
        logic [7:0] got;
        if (store) rxq.push_back(tx);
        txq.push_back(exp_miso);
        xfer(tx, 8, pop_hit, load_hit, load_val, got, tr);
        chk("master_rx", 32'(got), 32'(txq.pop_front()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sck = 1'b0; bus.mosi = 1'b0; bus.ss = 1'b1;
        bus.loadTx_data = '0; bus.EN_loadTx = 1'b0; bus.EN_getRx = 1'b0;
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 8'hC3, 8'hFF};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81};
        vecs[4] = '{1'b1, 8'h5A, 8'h00, 8'h5A};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_miso", 32'(bus.miso), 32'd1);
        chk("rst_miso_en", 32'(bus.miso_en), 32'd0);
        chk("rst_rdy_loadtx", 32'(bus.RDY_loadTx), 32'd1);
        chk("rst_rdy_getrx", 32'(bus.RDY_getRx), 32'd0);
        chk("rst_getrx", 32'(bus.getRx), 32'h00);
        chk("rst_selected", 32'(bus.selected), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);

        foreach (vecs[k]) begin
            if (vecs[k].load) begin
                load_tx(vecs[k].ld);
                chk("rdy_loadtx_busy", 32'(bus.RDY_loadTx), 32'd0);
            end
            bus.ss = 1'b0;
            byte_xfer(vecs[k].mosi, vecs[k].miso, 1'b1, 1'b0, 1'b0, 8'h00, rdy);
            chk("selected_active", 32'(bus.selected), 32'd1);
            chk("rdy_getrx_timing", 32'(rdy), 32'b1100);
            deselect();
            chk("rdy_loadtx_free", 32'(bus.RDY_loadTx), 32'd1);
            read_rx("rx_vec");
        end

        bus.ss = 1'b0;
        byte_xfer(8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, rdy);
        byte_xfer(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, rdy);
        deselect();
        chk("ovr_rdy_getrx", 32'(bus.RDY_getRx), 32'd1);
        chk("ovr_getrx_kept", 32'(bus.getRx), 32'h01);
        chk("ovr_flag_set", 32'(bus.overrun), 32'd1);
        read_rx("rx_ovr");
        chk("ovr_flag_cleared", 32'(bus.overrun), 32'd0);
        chk("ovr_rdy_after_pop", 32'(bus.RDY_getRx), 32'd0);

        bus.ss = 1'b0;
        xfer(8'hF0, 4, 1'b0, 1'b0, 8'h00, junk, rdy);
        bus.ss = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_miso_en_hold", 32'(bus.miso_en), 32'd1);
        @(negedge clk);
        chk("abort_miso_en_drop", 32'(bus.miso_en), 32'd0);
        repeat (H) @(negedge clk);
        chk("abort_no_rx", 32'(bus.RDY_getRx), 32'd0);
        bus.ss = 1'b0;
        byte_xfer(8'h55, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, rdy);
        deselect();
        read_rx("rx_after_abort");

        bus.ss = 1'b0;
        byte_xfer(8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, rdy);
        byte_xfer(8'h22, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, rdy);
        deselect();
        chk("pop_no_overrun", 32'(bus.overrun), 32'd0);
        chk("pop_rdy_getrx", 32'(bus.RDY_getRx), 32'd1);
        read_rx("rx_pop_second");

        bus.ss = 1'b0;
        byte_xfer(8'hA1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h7E, rdy);
        chk("ld_collide_held", 32'(bus.RDY_loadTx), 32'd0);
        byte_xfer(8'hB2, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, rdy);
        byte_xfer(8'hC3, 8'h7E, 1'b1, 1'b1, 1'b0, 8'h00, rdy);
        deselect();
        chk("ld_collide_drained", 32'(bus.RDY_loadTx), 32'd1);
        read_rx("rx_collide");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI Mode-0 responder for the far end of the `mkSPI` master link. It synchronises `sck`, `mosi` and `ss` into the system clock domain, assembles received bytes for the local consumer, and shifts transmit bytes out on `miso`, all MSB first. Received and transmitted bytes pass through single-entry holding registers using the codebase's EN_/RDY_ method handshake. It is the test responder for `mkSPI` benches and the peripheral-side model for board bring-up.

## Interface
- IDLE_BYTE, 8'hFF: byte shifted out when the TX holding register is empty at a byte start.
- SYNC_STAGES, 2: synchroniser depth for `sck`, `mosi` and `ss`; minimum 2.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- sck  in  1  SPI clock from the master (CPOL=0); asynchronous to CLK.
- mosi  in  1  master-out data, MSB first.
- ss  in  1  slave select, active-low.
- miso  out  1  slave-out data.
- miso_en  out  1  high while selected; drives the board tristate buffer.
- loadTx_data  in  8  next byte to transmit.
- EN_loadTx  in  1  writes `loadTx_data` into the TX holding register; legal only when RDY_loadTx=1.
- RDY_loadTx  out  1  TX holding register is empty.
- EN_getRx  in  1  pops the RX holding register; legal only when RDY_getRx=1.
- getRx  out  8  contents of the RX holding register.
- RDY_getRx  out  1  RX holding register is full.
- selected  out  1  synchronised, inverted `ss`.
- overrun  out  1  sticky flag; set when a received byte is dropped, cleared by EN_getRx.

## Operation
- States: IDLE (not selected) and ACTIVE. A synchronised `ss` falling edge moves IDLE to ACTIVE. A synchronised `ss` rising edge moves ACTIVE to IDLE.
- On entering ACTIVE:
  - Clear bitcnt (3-bit) to 0.
  - Load tx_shift from the TX holding register if it is full, and mark the holding register empty. Otherwise load IDLE_BYTE.
  - Set miso to tx_shift[7].
- On a synchronised `sck` rising edge in ACTIVE:
  - Shift the synchronised `mosi` into rx_shift[0] and increment bitcnt. bitcnt wraps 7 to 0.
  - On the 8th edge (bitcnt 7 to 0), write the assembled byte to the RX holding register.
  - If the RX holding register is full and EN_getRx is not asserted that cycle, keep the old byte, drop the new one, and set `overrun`.
- On a synchronised `sck` falling edge in ACTIVE:
  - If bitcnt≠0, shift tx_shift left and drive the next bit.
  - If bitcnt=0 (a byte just completed), load the next byte as on entering ACTIVE and drive its bit 7.
- `ss` deasserted mid-byte: discard the partial RX byte and write nothing. The TX byte already consumed is lost. bitcnt returns to 0.
- `sck` edges in IDLE are ignored.
- EN_loadTx in the same cycle as a byte-start load with the holding register empty: IDLE_BYTE is sent, and the new data stays in the holding register.
- EN_getRx in the same cycle as an RX write with the holding register full: the consumer takes the old byte, the new byte is stored, and `overrun` is not set.
- Reset values: miso=1, miso_en=0, RDY_loadTx=1, RDY_getRx=0, getRx=8'h00, selected=0, overrun=0, state IDLE, bitcnt=0.

## Timing
- Edge detection latency is SYNC_STAGES+1 CLK cycles from a pin transition to its effect on registers or outputs. That is 3 cycles at the default.
- miso/miso_en update ≤3 CLK cycles after a `ss` or `sck` transition at the pin.
- RDY_getRx rises 3 CLK cycles after the 8th `sck` rising edge at the pin.
- Master requirements:
  - `sck` high and low phases each ≥4 CLK cycles.
  - `ss` falling to first `sck` rising edge ≥4 CLK cycles.
  - Last `sck` falling edge to `ss` rising edge ≥4 CLK cycles.
- `mosi` passes through the same synchroniser depth as `sck`, so they stay sample-aligned.
- EN_ inputs take effect at the CLK edge where they are asserted. RDY_ outputs are registered.

## Structure
- Package `spi_pkg` holds:
  - SPI_BYTE_W=8.
  - The state enum {IDLE, ACTIVE}.
  - The default IDLE_BYTE constant, shared with the master-side bench.
- Sub-module `spi_sync_edge`: N-flop synchroniser plus a rise/fall detect register. It is instantiated for `sck` and `ss`; `mosi` uses its synchronised output only.

## Test plan
- Reset held, then released with ss=1 -> all outputs at their reset values and RDY_loadTx=1.
- loadTx 8'hA5; master sends 8'h3C with a 4-CLK half period -> master receives 8'hA5, getRx=8'h3C, RDY_getRx rises 3 cycles after the 8th rising edge, RDY_loadTx returns to 1 at the byte start.
- Two back-to-back bytes 8'h01, 8'h02 with no TX load -> master receives 8'hFF and 8'hFF; the first getRx is 8'h01. Without a read, the second byte is dropped, overrun=1, and getRx stays 8'h01. EN_getRx clears overrun.
- `ss` raised after 4 bits of 8'hF0 -> RDY_getRx stays 0, miso_en drops within 3 cycles, and the next full transfer of 8'h55 is received correctly.
- EN_getRx in the same cycle as the second byte's write -> no overrun, and the second byte is readable next.
- EN_loadTx 8'h7E in the same cycle as a byte-start load with the TX holding register empty -> that byte sends 8'hFF, and the next byte sends 8'h7E.
